// File: rtl/aibcr3aux_osc_pkg.sv
// Shared state encoding, default cycle counts and small helpers for the
// oscillator power-up sequencer.
package aibcr3aux_osc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PWRUP  = 3'd1,
    ST_VWAIT  = 3'd2,
    ST_TLOAD  = 3'd3,
    ST_SETTLE = 3'd4,
    ST_READY  = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

  localparam int PWRUP_CYC_DEF   = 32'd64;
  localparam int SETTLE_CYC_DEF  = 32'd256;
  localparam int TIMEOUT_CYC_DEF = 32'd1024;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    max3 = (m > c) ? m : c;
  endfunction

  // The oscillator is powered in every active sequencing state.
  function automatic logic pdb_on(input state_e s);
    case (s)
      ST_PWRUP, ST_VWAIT, ST_TLOAD, ST_SETTLE, ST_READY: pdb_on = 1'b1;
      default:                                           pdb_on = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/aibcr3aux_osc_sync.sv
// Two-stage reset-to-zero synchronizer for asynchronous level flags.
module aibcr3aux_osc_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two flop stages give metastability settling time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= {WIDTH{1'b0}};
      sync_r <= {WIDTH{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/aibcr3aux_osc_seq.sv
// Oscillator power-up / trim-load / settle sequencer.
// Define AIBCR3AUX_OSC_SEQ_TIMEOUT_EN to enable the sticky VWAIT timeout fault.
module aibcr3aux_osc_seq
  import aibcr3aux_osc_pkg::*;
#(
  parameter int PWRUP_CYC   = PWRUP_CYC_DEF,
  parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       iosc_clk,
  input  logic       irstb,
  input  logic       iseq_en,
  input  logic [2:0] iosc_cr_vreg_rdy,
  input  logic       ifuse_valid,
  input  logic [8:0] ifuse_trim,
  input  logic [8:0] icsr_trim,
  input  logic       icsr_trim_ovrd,
  input  logic       iseq_retrim,
  output logic       oosc_cr_pdb,
  output logic [8:0] oosc_cr_trim,
  output logic       oosc_cr_rdy_dly,
  output logic [2:0] oseq_state,
  output logic       oseq_fault
);

  localparam int CNT_MAX = max3(PWRUP_CYC, SETTLE_CYC, TIMEOUT_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PWRUP_LAST  = CNT_W'(PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};

  state_e           state_r;
  state_e           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic [2:0]       vreg_sync_s;
  logic             vreg_ok_s;
  logic             timeout_hit_s;
  logic             trim_ld_s;
  logic [8:0]       trim_sel_s;
  logic             pdb_r;
  logic             rdy_r;
  logic [8:0]       trim_r;

  aibcr3aux_osc_sync #(.WIDTH(3)) u_vreg_sync (
    .clk   (iosc_clk),
    .rst_n (irstb),
    .d     (iosc_cr_vreg_rdy),
    .q     (vreg_sync_s)
  );

  assign vreg_ok_s = &vreg_sync_s;

`ifdef AIBCR3AUX_OSC_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  assign timeout_hit_s = (cnt_r >= TIMEOUT_LAST);
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Next-state logic; dropping iseq_en outranks every other request.
  always_comb begin
    state_s = state_r;
    if ((state_r != ST_IDLE) && !iseq_en) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:   if (iseq_en) state_s = ST_PWRUP; else state_s = ST_IDLE;
        ST_PWRUP:  if (cnt_r >= PWRUP_LAST) state_s = ST_VWAIT; else state_s = ST_PWRUP;
        ST_VWAIT: begin
          if (vreg_ok_s)          state_s = ST_TLOAD;
          else if (timeout_hit_s) state_s = ST_FAULT;
          else                    state_s = ST_VWAIT;
        end
        ST_TLOAD:  state_s = ST_SETTLE;
        ST_SETTLE: if (cnt_r >= SETTLE_LAST) state_s = ST_READY; else state_s = ST_SETTLE;
        ST_READY: begin
          if (iseq_retrim)     state_s = ST_TLOAD;
          else if (!vreg_ok_s) state_s = ST_VWAIT;
          else                 state_s = ST_READY;
        end
        ST_FAULT:  state_s = ST_FAULT;
        default:   state_s = ST_IDLE;
      endcase
    end
  end

  // Saturating dwell counter, restarted on every state change; trim select.
  always_comb begin
    cnt_s      = cnt_r;
    trim_ld_s  = (state_r == ST_TLOAD) && (state_s == ST_SETTLE);
    trim_sel_s = ifuse_trim;
    if (state_s != state_r) begin
      cnt_s = {CNT_W{1'b0}};
    end else if (cnt_r != CNT_SAT) begin
      cnt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_s = cnt_r;
    end
    if (icsr_trim_ovrd || !ifuse_valid) begin
      trim_sel_s = icsr_trim;
    end else begin
      trim_sel_s = ifuse_trim;
    end
  end

  // State, counter and outputs; outputs follow the next state so they are glitch-free.
  always_ff @(posedge iosc_clk or negedge irstb) begin
    if (!irstb) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      pdb_r   <= 1'b0;
      rdy_r   <= 1'b0;
      trim_r  <= 9'h000;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      pdb_r   <= pdb_on(state_s);
      rdy_r   <= (state_s == ST_READY);
      if (trim_ld_s) begin
        trim_r <= trim_sel_s;
      end else begin
        trim_r <= trim_r;
      end
    end
  end

`ifdef AIBCR3AUX_OSC_SEQ_TIMEOUT_EN
  logic fault_r;

  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge iosc_clk or negedge irstb) begin
    if (!irstb) begin
      fault_r <= 1'b0;
    end else begin
      fault_r <= fault_r | (state_s == ST_FAULT);
    end
  end

  assign oseq_fault = fault_r;
`else
  assign oseq_fault = 1'b0;
`endif

  assign oosc_cr_pdb     = pdb_r;
  assign oosc_cr_rdy_dly = rdy_r;
  assign oosc_cr_trim    = trim_r;
  assign oseq_state      = state_r;

endmodule

// File: tb/tb_aibcr3aux_osc_seq.sv
// Randomized self-checking bench for aibcr3aux_osc_seq against a phase/deadline
// reference model; honours AIBCR3AUX_OSC_SEQ_TIMEOUT_EN like the design.
module tb_aibcr3aux_osc_seq;

  localparam int PWRUP   = 64;
  localparam int SETTLE  = 256;
  localparam int TIMEOUT = 1024;
`ifdef AIBCR3AUX_OSC_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int M_IDLE = 0, M_PWRUP = 1, M_VWAIT = 2, M_TLOAD = 3;
  localparam int M_SETTLE = 4, M_READY = 5, M_FAULT = 6;

  logic       iosc_clk = 1'b0;
  logic       irstb;
  logic       iseq_en;
  logic [2:0] iosc_cr_vreg_rdy;
  logic       ifuse_valid;
  logic [8:0] ifuse_trim;
  logic [8:0] icsr_trim;
  logic       icsr_trim_ovrd;
  logic       iseq_retrim;
  logic       oosc_cr_pdb;
  logic [8:0] oosc_cr_trim;
  logic       oosc_cr_rdy_dly;
  logic [2:0] oseq_state;
  logic       oseq_fault;

  int checks = 0;
  int errors = 0;

  // reference model: phase, entry time of the phase, and a 2-sample delay line for vreg
  int         m_st;
  int         m_t0;
  int         ecyc;
  logic [8:0] m_trim;
  logic       m_fault;
  logic [2:0] vq [2];

  always #5 iosc_clk = ~iosc_clk;

  aibcr3aux_osc_seq #(
    .PWRUP_CYC   (PWRUP),
    .SETTLE_CYC  (SETTLE),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .iosc_clk         (iosc_clk),
    .irstb            (irstb),
    .iseq_en          (iseq_en),
    .iosc_cr_vreg_rdy (iosc_cr_vreg_rdy),
    .ifuse_valid      (ifuse_valid),
    .ifuse_trim       (ifuse_trim),
    .icsr_trim        (icsr_trim),
    .icsr_trim_ovrd   (icsr_trim_ovrd),
    .iseq_retrim      (iseq_retrim),
    .oosc_cr_pdb      (oosc_cr_pdb),
    .oosc_cr_trim     (oosc_cr_trim),
    .oosc_cr_rdy_dly  (oosc_cr_rdy_dly),
    .oseq_state       (oseq_state),
    .oseq_fault       (oseq_fault)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st    = M_IDLE;
    m_t0    = 0;
    m_trim  = 9'h000;
    m_fault = 1'b0;
    vq[0]   = 3'b000;
    vq[1]   = 3'b000;
  endtask

  task automatic model_edge();
    logic vok;
    ecyc++;
    vok   = (vq[0] == 3'b111);
    vq[0] = vq[1];
    vq[1] = iosc_cr_vreg_rdy;
    if (m_st != M_IDLE && !iseq_en) begin
      m_st = M_IDLE;
    end else begin
      case (m_st)
        M_IDLE:   if (iseq_en) begin m_st = M_PWRUP; m_t0 = ecyc; end
        M_PWRUP:  if (ecyc - m_t0 == PWRUP) begin m_st = M_VWAIT; m_t0 = ecyc; end
        M_VWAIT: begin
          if (vok) m_st = M_TLOAD;
          else if (TO_EN && (ecyc - m_t0 == TIMEOUT)) begin m_st = M_FAULT; m_fault = 1'b1; end
        end
        M_TLOAD: begin
          m_trim = (icsr_trim_ovrd || !ifuse_valid) ? icsr_trim : ifuse_trim;
          m_st   = M_SETTLE;
          m_t0   = ecyc;
        end
        M_SETTLE: if (ecyc - m_t0 == SETTLE) m_st = M_READY;
        M_READY: begin
          if (iseq_retrim) m_st = M_TLOAD;
          else if (!vok) begin m_st = M_VWAIT; m_t0 = ecyc; end
        end
        default: m_st = m_st;
      endcase
    end
  endtask

  task automatic compare_all();
    check_eq("state", 32'(oseq_state), 32'(m_st));
    check_eq("pdb", 32'(oosc_cr_pdb), 32'(m_st >= M_PWRUP && m_st <= M_READY));
    check_eq("rdy", 32'(oosc_cr_rdy_dly), 32'(m_st == M_READY));
    check_eq("trim", 32'(oosc_cr_trim), 32'(m_trim));
    check_eq("fault", 32'(oseq_fault), 32'(m_fault));
  endtask

  task automatic tick();
    @(posedge iosc_clk);
    if (!irstb) model_reset();
    else model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    int n;
    logic [8:0] held_trim;
    irstb = 1'b0; iseq_en = 1'b0; iosc_cr_vreg_rdy = 3'b111;
    ifuse_valid = 1'b1; ifuse_trim = 9'h0A5; icsr_trim = 9'h000;
    icsr_trim_ovrd = 1'b0; iseq_retrim = 1'b0;
    ecyc = 0;
    model_reset();
    for (int i = 0; i < 3; i++) tick();
    irstb = 1'b1;
    iseq_en = 1'b1;

    // power-up to ready: pdb on clock 1, ready after PWRUP + VWAIT + TLOAD + SETTLE
    begin
      int p_at, r_at;
      p_at = 0; r_at = 0;
      for (int i = 1; i <= 1000 && r_at == 0; i++) begin
        tick();
        if (p_at == 0 && oosc_cr_pdb) p_at = i;
        if (oosc_cr_rdy_dly) r_at = i;
      end
      check_eq("pdb_rise_clk", p_at, 1);
      check_eq("rdy_rise_clk", r_at, 1 + PWRUP + 1 + 1 + SETTLE);
      check_eq("fuse_trim", 32'(oosc_cr_trim), 32'h0A5);
    end

    // CSR override retrim
    icsr_trim_ovrd = 1'b1; icsr_trim = 9'h13C; iseq_retrim = 1'b1;
    tick();
    iseq_retrim = 1'b0;
    check_eq("retrim_rdy_drop", 32'(oosc_cr_rdy_dly), 32'd0);
    n = 0;
    while (!oosc_cr_rdy_dly && n < 400) begin tick(); n++; end
    check_eq("retrim_rdy_back", n, 1 + SETTLE);
    check_eq("csr_trim", 32'(oosc_cr_trim), 32'h13C);

    // regulator loss and recovery
    iosc_cr_vreg_rdy = 3'b011;
    n = 0;
    while (oosc_cr_rdy_dly && n < 10) begin tick(); n++; end
    check_eq("vloss_clks", n, 3);
    check_eq("vloss_state", 32'(oseq_state), 32'd2);
    iosc_cr_vreg_rdy = 3'b111;
    n = 0;
    while (!oosc_cr_rdy_dly && n < 400) begin tick(); n++; end
    check_eq("vback_clks", n, 3 + 1 + SETTLE);

    // regulator never comes back: timeout behaviour depends on the build
    iosc_cr_vreg_rdy = 3'b011;
    for (int i = 0; i < TIMEOUT + 20; i++) tick();
    check_eq("to_state", 32'(oseq_state), TO_EN ? 32'd6 : 32'd2);
    check_eq("to_fault", 32'(oseq_fault), TO_EN ? 32'd1 : 32'd0);
    check_eq("to_pdb", 32'(oosc_cr_pdb), TO_EN ? 32'd0 : 32'd1);
    iseq_en = 1'b0;
    tick();
    check_eq("to_exit_idle", 32'(oseq_state), 32'd0);
    check_eq("to_fault_sticky", 32'(oseq_fault), TO_EN ? 32'd1 : 32'd0);

    // disable during SETTLE together with a retrim request
    iosc_cr_vreg_rdy = 3'b111; iseq_en = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    check_eq("in_settle", 32'(oseq_state), 32'd4);
    held_trim = oosc_cr_trim;
    iseq_en = 1'b0; iseq_retrim = 1'b1; icsr_trim = 9'h0F0;
    tick();
    iseq_retrim = 1'b0;
    check_eq("abort_state", 32'(oseq_state), 32'd0);
    check_eq("abort_pdb", 32'(oosc_cr_pdb), 32'd0);
    check_eq("abort_trim", 32'(oosc_cr_trim), 32'(held_trim));

    // asynchronous reset in the middle of PWRUP
    iseq_en = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    #2 irstb = 1'b0;
    #1;
    check_eq("arst_state", 32'(oseq_state), 32'd0);
    check_eq("arst_pdb", 32'(oosc_cr_pdb), 32'd0);
    check_eq("arst_rdy", 32'(oosc_cr_rdy_dly), 32'd0);
    check_eq("arst_trim", 32'(oosc_cr_trim), 32'd0);
    check_eq("arst_fault", 32'(oseq_fault), 32'd0);
    model_reset();
    tick();
    irstb = 1'b1;

    // randomized soak
    for (int i = 0; i < 6000; i++) begin
      iseq_retrim = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 699) == 0) iseq_en = ~iseq_en;
      if ($urandom_range(0, 249) == 0) iosc_cr_vreg_rdy = 3'($urandom_range(0, 7));
      else if ($urandom_range(0, 39) == 0) iosc_cr_vreg_rdy = 3'b111;
      if ($urandom_range(0, 49) == 0) begin
        ifuse_trim     = 9'($urandom);
        icsr_trim      = 9'($urandom);
        ifuse_valid    = 1'($urandom);
        icsr_trim_ovrd = 1'($urandom);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
